// File: rtl/vga_ram_pkg.sv
// vga_ram_pkg: shared defaults, clear-state encoding and byte-lane helper for vga_text_ram
package vga_ram_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 12;

    typedef enum logic {CLR_IDLE, CLR_FILL} clr_state_t;

    function automatic int lanes(input int data_w);
        return data_w / 8;
    endfunction
endpackage

// File: rtl/vga_ram_clear_fsm.sv
// vga_ram_clear_fsm: sweeps a fill word over the whole array; only built with VGA_RAM_CLEAR_EN
`ifdef VGA_RAM_CLEAR_EN
module vga_ram_clear_fsm
    import vga_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] fill_in,
    output logic              busy,
    output logic              done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);
    clr_state_t        state, state_next;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] fill;
    logic              last;

    assign busy    = state == CLR_FILL;
    assign last    = &ptr;
    // A reset landing mid-sweep must not commit the write of that cycle.
    assign wr_en   = busy && !rst;
    assign wr_addr = ptr;
    assign wr_data = fill;

    always_comb begin
        state_next = state;
        state_next = busy ? (last ? CLR_IDLE : CLR_FILL) : (start ? CLR_FILL : CLR_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLR_IDLE;
            ptr   <= '0;
            fill  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= busy && last;
            ptr   <= busy ? ptr + 1'b1 : '0;
            if (!busy && start) fill <= fill_in;
        end
    end
endmodule
`endif

// File: rtl/vga_text_ram.sv
// vga_text_ram: dual-port char/attr RAM, byte-enabled CPU port A, read-only display port B,
// optional whole-array fill engine enabled by VGA_RAM_CLEAR_EN.
module vga_text_ram
    import vga_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_en,
    input  logic                a_we,
    input  logic [DATA_W/8-1:0] a_be,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_wdata,
    output logic                a_ready,
    output logic [DATA_W-1:0]   a_rdata,
    output logic                a_rvalid,
    input  logic [ADDR_W-1:0]   b_addr,
    output logic [DATA_W-1:0]   b_rdata,
    input  logic                clr_start,
    input  logic [DATA_W-1:0]   clr_data,
    output logic                clr_busy,
    output logic                clr_done
);
    localparam int LANES = lanes(DATA_W);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic              accept, c_en, w_en;
    logic [ADDR_W-1:0] c_addr, w_addr;
    logic [DATA_W-1:0] c_data, w_data;
    logic [LANES-1:0]  w_be;

`ifdef VGA_RAM_CLEAR_EN
    vga_ram_clear_fsm #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_clear (
        .clk     (clk),
        .rst     (rst),
        .start   (clr_start),
        .fill_in (clr_data),
        .busy    (clr_busy),
        .done    (clr_done),
        .wr_en   (c_en),
        .wr_addr (c_addr),
        .wr_data (c_data)
    );
`else
    logic unused_clr;
    assign unused_clr = ^{clr_start, clr_data};
    assign clr_busy   = 1'b0;
    assign clr_done   = 1'b0;
    assign c_en       = 1'b0;
    assign c_addr     = '0;
    assign c_data     = '0;
`endif

    assign a_ready = !clr_busy;
    assign accept  = a_en && a_ready;
    // The fill engine owns the write port while busy; port A is held off through a_ready.
    assign w_en    = c_en || (accept && a_we);
    assign w_addr  = c_en ? c_addr : a_addr;
    assign w_data  = c_en ? c_data : a_wdata;
    assign w_be    = c_en ? '1 : a_be;

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++)
            if (w_en && w_be[i]) mem[w_addr][8*i +: 8] <= w_data[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_rdata  <= '0;
            a_rvalid <= 1'b0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= accept;
            if (accept) a_rdata <= mem[a_addr];
            b_rdata  <= mem[b_addr];
        end
    end
endmodule

// File: tb/tb_vga_text_ram.sv
// tb_vga_text_ram: per-cycle expectation queue drained by an independent monitor.
module tb_vga_text_ram;
    typedef struct packed {
        logic        ca;
        logic        av;
        logic        cd;
        logic [15:0] ad;
        logic        cb;
        logic [15:0] bd;
        logic        cs;
        logic        busy;
        logic        done;
        logic        rz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, a_en, a_we, clr_start;
    logic [1:0]  a_be;
    logic [11:0] a_addr, b_addr;
    logic [15:0] a_wdata, clr_data;
    logic        a_ready, a_rvalid, clr_busy, clr_done;
    logic [15:0] a_rdata, b_rdata;

    exp_t q[$];
    exp_t me;
    int   vectors = 0;
    int   miscompares = 0;

    vga_text_ram #(.DATA_W(16), .ADDR_W(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_en      (a_en),
        .a_we      (a_we),
        .a_be      (a_be),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_ready   (a_ready),
        .a_rdata   (a_rdata),
        .a_rvalid  (a_rvalid),
        .b_addr    (b_addr),
        .b_rdata   (b_rdata),
        .clr_start (clr_start),
        .clr_data  (clr_data),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic ca, av, cd, input logic [15:0] ad,
                                input logic cb, input logic [15:0] bd,
                                input logic cs, busy, done);
        exp_t e;
        e = '{ca: ca, av: av, cd: cd, ad: ad, cb: cb, bd: bd, cs: cs, busy: busy, done: done, rz: 1'b0};
        return e;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            me = q.pop_front();
            if (me.ca) chk("a_rvalid", {15'b0, a_rvalid}, {15'b0, me.av});
            if (me.cd) chk("a_rdata", a_rdata, me.ad);
            if (me.rz) chk("a_rdata_reset", a_rdata, 16'h0000);
            if (me.cb) chk("b_rdata", b_rdata, me.bd);
            if (me.cs) begin
                chk("clr_busy", {15'b0, clr_busy}, {15'b0, me.busy});
                chk("a_ready", {15'b0, a_ready}, {15'b0, !me.busy});
                chk("clr_done", {15'b0, clr_done}, {15'b0, me.done});
            end
        end
    end

    task automatic drive(input logic en, we, input logic [1:0] be, input logic [11:0] ad, input logic [15:0] wd);
        a_en = en;
        a_we = we;
        a_be = be;
        a_addr = ad;
        a_wdata = wd;
    endtask

    task automatic cyc(input exp_t e);
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic nop_cs(input logic busy, input logic done);
        drive(1'b0, 1'b0, 2'b00, 12'h000, 16'h0000);
        cyc(mk(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, busy, done));
    endtask

    task automatic wr(input logic [11:0] ad, input logic [1:0] be, input logic [15:0] wd,
                      input logic cd, input logic [15:0] old);
        drive(1'b1, 1'b1, be, ad, wd);
        cyc(mk(1'b1, 1'b1, cd, old, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0));
    endtask

    task automatic rd(input logic [11:0] ad, input logic [15:0] v);
        drive(1'b1, 1'b0, 2'b00, ad, 16'h0000);
        cyc(mk(1'b1, 1'b1, 1'b1, v, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0));
    endtask

    task automatic bchk(input logic [11:0] ad, input logic [15:0] v);
        drive(1'b0, 1'b0, 2'b00, 12'h000, 16'h0000);
        b_addr = ad;
        cyc(mk(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, v, 1'b1, 1'b0, 1'b0));
    endtask

    initial begin
        exp_t e;
        logic [11:0] ra;
        rst = 1'b1;
        clr_start = 1'b0;
        clr_data = 16'h0000;
        b_addr = 12'h000;
        drive(1'b0, 1'b0, 2'b00, 12'h000, 16'h0000);
        @(negedge clk);
        e = mk(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        e.rz = 1'b1;
        cyc(e);
        cyc(e);
        rst = 1'b0;

        wr(12'h010, 2'b11, 16'h4142, 1'b0, 16'h0);
        rd(12'h010, 16'h4142);
        bchk(12'h010, 16'h4142);
        wr(12'h020, 2'b11, 16'hFFFF, 1'b0, 16'h0);
        wr(12'h020, 2'b01, 16'h1234, 1'b1, 16'hFFFF);
        rd(12'h020, 16'hFF34);
        wr(12'h030, 2'b11, 16'h5555, 1'b0, 16'h0);
        drive(1'b1, 1'b1, 2'b11, 12'h030, 16'hAAAA);
        b_addr = 12'h030;
        cyc(mk(1'b1, 1'b1, 1'b1, 16'h5555, 1'b1, 16'h5555, 1'b1, 1'b0, 1'b0));
        bchk(12'h030, 16'hAAAA);
        wr(12'h030, 2'b00, 16'h0000, 1'b1, 16'hAAAA);
        rd(12'h030, 16'hAAAA);
        wr(12'h031, 2'b10, 16'h9900, 1'b0, 16'h0);
        wr(12'h031, 2'b01, 16'h0077, 1'b0, 16'h0);
        bchk(12'h030, 16'hAAAA);

`ifdef VGA_RAM_CLEAR_EN
        wr(12'h800, 2'b11, 16'h1111, 1'b0, 16'h0);
        // Port A write in the start cycle is accepted, then the sweep overwrites it.
        drive(1'b1, 1'b1, 2'b11, 12'h100, 16'hBEEF);
        clr_start = 1'b1;
        clr_data = 16'h0720;
        cyc(mk(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0));
        clr_start = 1'b0;
        clr_data = 16'h0000;
        for (int j = 0; j < 4096; j++) begin
            drive(1'b0, 1'b0, 2'b00, 12'h000, 16'h0000);
            if (j == 10 || j == 12) drive(1'b1, 1'b0, 2'b00, 12'h010, 16'h0000);
            if (j == 11) drive(1'b1, 1'b1, 2'b11, 12'h005, 16'hDEAD);
            clr_start = (j == 100);
            clr_data = (j == 100) ? 16'h1234 : 16'h0000;
            cyc(mk(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, j < 4095, j == 4095));
        end
        clr_start = 1'b0;
        nop_cs(1'b0, 1'b0);
        rd(12'h100, 16'h0720);
        rd(12'h005, 16'h0720);
        rd(12'h800, 16'h0720);
        rd(12'hFFF, 16'h0720);
        for (int k = 0; k < 8; k++) begin
            ra = 12'($urandom_range(4095));
            bchk(ra, 16'h0720);
        end

        wr(12'd49, 2'b11, 16'h1357, 1'b1, 16'h0720);
        wr(12'd51, 2'b11, 16'h1357, 1'b1, 16'h0720);
        drive(1'b0, 1'b0, 2'b00, 12'h000, 16'h0000);
        clr_start = 1'b1;
        clr_data = 16'h5A5A;
        cyc(mk(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0));
        clr_start = 1'b0;
        for (int j = 0; j < 50; j++) nop_cs(1'b1, 1'b0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 12'h000, 16'h0000);
        e = mk(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        e.rz = 1'b1;
        cyc(e);
        rst = 1'b0;
        repeat (3) nop_cs(1'b0, 1'b0);
        rd(12'd0, 16'h5A5A);
        rd(12'd49, 16'h5A5A);
        rd(12'd51, 16'h1357);
        rd(12'd52, 16'h0720);
        rd(12'h800, 16'h0720);
`else
        drive(1'b0, 1'b0, 2'b00, 12'h000, 16'h0000);
        clr_start = 1'b1;
        clr_data = 16'h0720;
        cyc(mk(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0));
        clr_start = 1'b0;
        repeat (3) nop_cs(1'b0, 1'b0);
        rd(12'h010, 16'h4142);
        rd(12'h020, 16'hFF34);
`endif
        drive(1'b0, 1'b0, 2'b00, 12'h000, 16'h0000);
        repeat (4) @(negedge clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
